sseg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a 4-digit, common-anode seven-segment display.
- Holds four hex digits and four decimal points in a double buffer; a valid/ready load port feeds the buffer.
- Cycles one digit per slot, with a blanking dead-time at the start of each slot to suppress ghosting.
- Commits new data only at frame boundaries, so the display never tears.
- Sits between switch/register logic and the board's an/sseg pins.

---
 rtl/sseg_scan_ctrl.sv | 153 +++++++++++++++
 tb/tb_sseg_scan_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_ctrl.sv
// Scan controller for a 4-digit common-anode seven-segment display with a double-buffered load port.
// Optional leading-zero blanking is enabled by defining SSEG_LZ_BLANK_EN.
module sseg_scan_ctrl #(
    parameter int SLOT_CYC  = 65536,  // cycles per digit slot, >= 2
    parameter int BLANK_CYC = 256     // dead-time cycles at slot start, < SLOT_CYC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [15:0] ld_data,
    input  logic [3:0]  ld_dp,
    output logic [3:0]  an,
    output logic [7:0]  sseg,
    output logic        frame_tick
);

    localparam int CNT_W = $clog2(SLOT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT_CYC - 1);
    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYC);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } load_state_t;

    // Active-low g..a pattern for one hex digit, dp excluded.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // A digit is a leading zero when it and every digit above it are 0 with dp off.
    function automatic logic [3:0] lead_zero_mask(input logic [15:0] data, input logic [3:0] dp);
        logic [3:0] m;
        m[3] = (data[15:12] == 4'h0) && !dp[3];
        m[2] = m[3] && (data[11:8] == 4'h0) && !dp[2];
        m[1] = m[2] && (data[7:4] == 4'h0) && !dp[1];
        m[0] = 1'b0;
        return m;
    endfunction

    logic [CNT_W-1:0] cnt_p0;
    logic [1:0]       idx_p0;
    logic             frame_end_p0;
    logic             blank_p0;
    logic [3:0]       digit_p0;
    logic             dp_p0;
    logic [3:0]       lz_mask;

    logic [15:0]      disp_data;
    logic [3:0]       disp_dp;
    logic [15:0]      pend_data;
    logic [3:0]       pend_dp;
    load_state_t      load_state;

    // ---- stage p0: slot/digit scan counters ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_p0 <= '0;
            idx_p0 <= '0;
        end else if (cnt_p0 == CNT_LAST) begin
            cnt_p0 <= '0;
            idx_p0 <= idx_p0 + 2'd1;
        end else begin
            cnt_p0 <= cnt_p0 + CNT_W'(1);
        end
    end

    assign frame_end_p0 = (idx_p0 == 2'd3) && (cnt_p0 == CNT_LAST);
    assign blank_p0     = (cnt_p0 < BLANK_LIM);
    assign digit_p0     = disp_data[{idx_p0, 2'b00} +: 4];
    assign dp_p0        = disp_dp[idx_p0];

`ifdef SSEG_LZ_BLANK_EN
    assign lz_mask = lead_zero_mask(disp_data, disp_dp);
`else
    assign lz_mask = 4'b0000;
`endif

    // Load handshake: pend buffer is written on accept and drained into the
    // display buffer only at frame_end, so a frame is never torn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_state <= ST_IDLE;
            ld_ready   <= 1'b1;
            pend_data  <= '0;
            pend_dp    <= '0;
            disp_data  <= '0;
            disp_dp    <= '0;
        end else begin
            case (load_state)
                ST_IDLE: begin
                    if (ld_valid) begin
                        pend_data  <= ld_data;
                        pend_dp    <= ld_dp;
                        load_state <= ST_PEND;
                        ld_ready   <= 1'b0;
                    end
                end
                ST_PEND: begin
                    if (frame_end_p0) begin
                        disp_data  <= pend_data;
                        disp_dp    <= pend_dp;
                        load_state <= ST_IDLE;
                        ld_ready   <= 1'b1;
                    end
                end
                default: begin
                    load_state <= ST_IDLE;
                    ld_ready   <= 1'b1;
                end
            endcase
        end
    end

    // ---- stage p1: registered pin drivers ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an         <= 4'hF;
            sseg       <= 8'hFF;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frame_end_p0;
            if (blank_p0 || lz_mask[idx_p0]) begin
                an   <= 4'hF;
                sseg <= 8'hFF;
            end else begin
                an   <= ~(4'b0001 << idx_p0);
                sseg <= {~dp_p0, seg_decode(digit_p0)};
            end
        end
    end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Self-checking bench for sseg_scan_ctrl: directed frame captures plus randomized loads against a frame-time model.
`timescale 1ns/1ps
module tb_sseg_scan_ctrl;

    localparam int SLOT  = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 4 * SLOT;

`ifdef SSEG_LZ_BLANK_EN
    localparam bit LZ_ON = 1'b1;
`else
    localparam bit LZ_ON = 1'b0;
`endif
    localparam logic [7:0] ZD = LZ_ON ? 8'hFF : 8'hC0;

    localparam logic [7:0] SEG_LUT [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ld_valid = 1'b0;
    logic [15:0] ld_data = '0;
    logic [3:0]  ld_dp = '0;
    logic        ld_ready;
    logic [3:0]  an;
    logic [7:0]  sseg;
    logic        frame_tick;

    int n_cmp = 0;
    int n_fail = 0;

    sseg_scan_ctrl #(.SLOT_CYC(SLOT), .BLANK_CYC(BLANK)) dut (
        .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_data(ld_data), .ld_dp(ld_dp), .an(an), .sseg(sseg), .frame_tick(frame_tick));

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] seg_of(input logic [3:0] d, input logic dp);
        logic [7:0] v;
        v = SEG_LUT[d];
        return {~dp, v[6:0]};
    endfunction

    function automatic logic [3:0] lz_of(input logic [15:0] data, input logic [3:0] dp);
        logic [3:0] r;
        r = 4'b0000;
        if (LZ_ON) begin
            for (int k = 1; k < 4; k++) begin
                r[k] = 1'b1;
                for (int j = k; j < 4; j++)
                    if (data[4*j +: 4] != 4'h0 || dp[j]) r[k] = 1'b0;
            end
        end
        return r;
    endfunction

    // Reference model: position in frame derived from elapsed cycles since reset.
    int unsigned t_m;
    logic [15:0] disp_m, pend_m;
    logic [3:0]  dpd_m, pendp_m;
    logic        pending_m;
    logic [3:0]  exp_an;
    logic [7:0]  exp_sseg;
    logic        exp_tick;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_m <= 0; disp_m <= '0; dpd_m <= '0; pend_m <= '0; pendp_m <= '0;
            pending_m <= 1'b0; exp_an <= 4'hF; exp_sseg <= 8'hFF; exp_tick <= 1'b0;
        end else begin
            int pos;
            int slot;
            int off;
            logic [3:0] lz;
            pos  = int'(t_m % FRAME);
            slot = pos / SLOT;
            off  = pos % SLOT;
            lz   = lz_of(disp_m, dpd_m);
            if (off < BLANK || lz[slot]) begin
                exp_an   <= 4'hF;
                exp_sseg <= 8'hFF;
            end else begin
                exp_an   <= ~(4'b0001 << slot);
                exp_sseg <= seg_of(disp_m[4*slot +: 4], dpd_m[slot]);
            end
            exp_tick <= (pos == FRAME - 1);
            if (ld_valid && !pending_m) begin
                pend_m <= ld_data; pendp_m <= ld_dp; pending_m <= 1'b1;
            end else if (pos == FRAME - 1 && pending_m) begin
                disp_m <= pend_m; dpd_m <= pendp_m; pending_m <= 1'b0;
            end
            t_m <= t_m + 1;
        end
    end

    task automatic wait_tick(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (frame_tick) break;
        end
        if (i == budget) begin
            n_cmp++; n_fail++;
            $display("FAIL wait_tick: no frame_tick within %0d cycles", budget);
        end
    endtask

    // Records the sseg value shown on each digit until the next frame_tick.
    task automatic capture_frame(output logic [31:0] segs);
        int i;
        segs = '1;
        for (i = 0; i < FRAME + 4; i++) begin
            @(negedge clk);
            case (an)
                4'b1110: segs[7:0]   = sseg;
                4'b1101: segs[15:8]  = sseg;
                4'b1011: segs[23:16] = sseg;
                4'b0111: segs[31:24] = sseg;
                default: ;
            endcase
            if (frame_tick) break;
        end
        if (i == FRAME + 4) begin
            n_cmp++; n_fail++;
            $display("FAIL capture_frame: no frame_tick within %0d cycles", FRAME + 4);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ld_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (an !== 4'hF) begin n_fail++; $display("FAIL reset_an: an=%h expected F", an); end
        n_cmp++; if (sseg !== 8'hFF) begin n_fail++; $display("FAIL reset_sseg: sseg=%h expected FF", sseg); end
        n_cmp++; if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: tick=%b expected 0", frame_tick); end
        n_cmp++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: ld_ready=%b expected 1", ld_ready); end
    endtask

    task automatic test_scan();
        int pos, slot, off;
        logic [3:0] e_an;
        logic [7:0] e_sseg;
        rst_n = 1'b1;
        for (int c = 1; c <= 2 * FRAME; c++) begin
            @(negedge clk);
            pos = (c - 1) % FRAME; slot = pos / SLOT; off = pos % SLOT;
            if (off >= BLANK && (slot == 0 || !LZ_ON)) begin
                e_an = ~(4'b0001 << slot); e_sseg = 8'hC0;
            end else begin
                e_an = 4'hF; e_sseg = 8'hFF;
            end
            n_cmp++; if (an !== e_an) begin n_fail++; $display("FAIL scan_an c=%0d: an=%h expected %h", c, an, e_an); end
            n_cmp++; if (sseg !== e_sseg) begin n_fail++; $display("FAIL scan_sseg c=%0d: sseg=%h expected %h", c, sseg, e_sseg); end
            n_cmp++; if (frame_tick !== (pos == FRAME - 1)) begin n_fail++; $display("FAIL scan_tick c=%0d: tick=%b expected %b", c, frame_tick, pos == FRAME - 1); end
        end
    endtask

    task automatic test_load_mid_frame();
        logic [31:0] segs;
        logic [31:0] exp;
        int i;
        exp = {8'hF9, 8'hA4, 8'hB0, 8'h99};
        repeat (5) @(negedge clk);
        ld_valid = 1'b1; ld_data = 16'h1234; ld_dp = 4'b0000;
        @(negedge clk);
        ld_valid = 1'b0;
        n_cmp++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL load_ready_low: ld_ready=%b expected 0", ld_ready); end
        for (i = 0; i < FRAME + 4; i++) begin
            @(negedge clk);
            if (frame_tick) break;
            n_cmp++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL load_hold: ld_ready=%b expected 0", ld_ready); end
        end
        n_cmp++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL load_ready_rise: ld_ready=%b expected 1", ld_ready); end
        capture_frame(segs);
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (segs[8*k +: 8] !== exp[8*k +: 8]) begin n_fail++; $display("FAIL load_1234 digit%0d: sseg=%h expected %h", k, segs[8*k +: 8], exp[8*k +: 8]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] segs;
        logic [31:0] exp;
        int i;
        repeat (3) @(negedge clk);
        ld_valid = 1'b1; ld_data = 16'hABCD; ld_dp = 4'b0000;
        @(negedge clk);
        ld_data = 16'h0001;
        n_cmp++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_stall: ld_ready=%b expected 0", ld_ready); end
        for (i = 0; i < FRAME + 4; i++) begin
            @(negedge clk);
            if (frame_tick) break;
            n_cmp++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_hold: ld_ready=%b expected 0", ld_ready); end
        end
        n_cmp++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_commit1: ld_ready=%b expected 1", ld_ready); end
        @(negedge clk);
        ld_valid = 1'b0;
        n_cmp++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_accept2: ld_ready=%b expected 0", ld_ready); end
        capture_frame(segs);
        exp = {8'h88, 8'h83, 8'hC6, 8'hA1};
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (segs[8*k +: 8] !== exp[8*k +: 8]) begin n_fail++; $display("FAIL b2b_abcd digit%0d: sseg=%h expected %h", k, segs[8*k +: 8], exp[8*k +: 8]); end
        end
        n_cmp++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_commit2: ld_ready=%b expected 1", ld_ready); end
        capture_frame(segs);
        exp = {ZD, ZD, ZD, 8'hF9};
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (segs[8*k +: 8] !== exp[8*k +: 8]) begin n_fail++; $display("FAIL b2b_0001 digit%0d: sseg=%h expected %h", k, segs[8*k +: 8], exp[8*k +: 8]); end
        end
    endtask

    task automatic test_frame_end_load();
        logic [31:0] segs;
        logic [31:0] exp;
        repeat (FRAME - 1) @(negedge clk);
        ld_valid = 1'b1; ld_data = 16'h00DE; ld_dp = 4'b0000;
        @(negedge clk);
        ld_valid = 1'b0;
        n_cmp++; if (frame_tick !== 1'b1) begin n_fail++; $display("FAIL fe_align: tick=%b expected 1", frame_tick); end
        n_cmp++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL fe_accept: ld_ready=%b expected 0", ld_ready); end
        capture_frame(segs);
        exp = {ZD, ZD, ZD, 8'hF9};
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (segs[8*k +: 8] !== exp[8*k +: 8]) begin n_fail++; $display("FAIL fe_old digit%0d: sseg=%h expected %h", k, segs[8*k +: 8], exp[8*k +: 8]); end
        end
        n_cmp++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL fe_commit: ld_ready=%b expected 1", ld_ready); end
        capture_frame(segs);
        exp = {ZD, ZD, 8'hA1, 8'h86};
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (segs[8*k +: 8] !== exp[8*k +: 8]) begin n_fail++; $display("FAIL fe_new digit%0d: sseg=%h expected %h", k, segs[8*k +: 8], exp[8*k +: 8]); end
        end
    endtask

    task automatic test_decimal_points();
        logic [31:0] segs;
        logic [31:0] exp;
        exp = {8'h80, 8'h00, 8'h80, 8'h00};
        ld_valid = 1'b1; ld_data = 16'h8888; ld_dp = 4'b0101;
        @(negedge clk);
        ld_valid = 1'b0;
        wait_tick(FRAME + 4);
        capture_frame(segs);
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (segs[8*k +: 8] !== exp[8*k +: 8]) begin n_fail++; $display("FAIL dp_8888 digit%0d: sseg=%h expected %h", k, segs[8*k +: 8], exp[8*k +: 8]); end
        end
    endtask

    task automatic test_reset_mid_load();
        logic [31:0] segs;
        logic [31:0] exp;
        exp = {ZD, ZD, ZD, 8'hC0};
        repeat (3) @(negedge clk);
        ld_valid = 1'b1; ld_data = 16'h5555; ld_dp = 4'b1111;
        @(negedge clk);
        ld_valid = 1'b0;
        n_cmp++; if (an !== 4'b1110) begin n_fail++; $display("FAIL rstmid_pre_an: an=%h expected E", an); end
        n_cmp++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_pre_ready: ld_ready=%b expected 0", ld_ready); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (an !== 4'hF) begin n_fail++; $display("FAIL rstmid_an: an=%h expected F", an); end
        n_cmp++; if (sseg !== 8'hFF) begin n_fail++; $display("FAIL rstmid_sseg: sseg=%h expected FF", sseg); end
        n_cmp++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: ld_ready=%b expected 1", ld_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        capture_frame(segs);
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (segs[8*k +: 8] !== exp[8*k +: 8]) begin n_fail++; $display("FAIL rstmid_frame digit%0d: sseg=%h expected %h", k, segs[8*k +: 8], exp[8*k +: 8]); end
        end
    endtask

    task automatic test_leading_zero();
        logic [31:0] segs;
        logic [31:0] exp;
        exp = {ZD, ZD, 8'h88, 8'h92};
        ld_valid = 1'b1; ld_data = 16'h00A5; ld_dp = 4'b0000;
        @(negedge clk);
        ld_valid = 1'b0;
        wait_tick(FRAME + 4);
        capture_frame(segs);
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (segs[8*k +: 8] !== exp[8*k +: 8]) begin n_fail++; $display("FAIL lz_00a5 digit%0d: sseg=%h expected %h", k, segs[8*k +: 8], exp[8*k +: 8]); end
        end
    endtask

    task automatic test_random();
        int nz;
        logic [15:0] mask;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (rst_n) begin
                n_cmp++; if (an !== exp_an) begin n_fail++; $display("FAIL rnd_an c=%0d: an=%h expected %h", c, an, exp_an); end
                n_cmp++; if (sseg !== exp_sseg) begin n_fail++; $display("FAIL rnd_sseg c=%0d: sseg=%h expected %h", c, sseg, exp_sseg); end
                n_cmp++; if (frame_tick !== exp_tick) begin n_fail++; $display("FAIL rnd_tick c=%0d: tick=%b expected %b", c, frame_tick, exp_tick); end
                n_cmp++; if (ld_ready !== !pending_m) begin n_fail++; $display("FAIL rnd_ready c=%0d: ld_ready=%b expected %b", c, ld_ready, !pending_m); end
            end
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
            if (!(ld_valid && !ld_ready)) begin
                ld_valid = ($urandom_range(0, 3) == 0);
                nz = $urandom_range(0, 4);
                mask = (nz == 4) ? 16'hFFFF : 16'((32'd1 << (4 * nz)) - 1);
                ld_data = 16'($urandom) & mask;
                ld_dp = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            end
        end
        ld_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load_mid_frame();
        test_back_to_back();
        test_frame_end_load();
        test_decimal_points();
        test_reset_mid_load();
        test_leading_zero();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
